demux2_stream: RTL and testbench
================================

# demux2_stream

Two-way packet demultiplexer with valid/ready handshakes; it is the inverse of the team's `mux2`. It accepts one input stream of WIDTH-bit beats and steers each packet, delimited by `in_last`, to one of two output streams. The select is taken on the first beat of a packet and held until the last beat. Each output has a one-entry output register, and each output keeps a count of completed packets.

## Interface
- `WIDTH`, 16, beat width in bits.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset; release is synchronised externally.
- `in_data`  in  WIDTH  input beat.
- `in_sel`  in  1  destination select, sampled on the first beat only: 0 routes to `out_1`, 1 routes to `out_2`.
- `in_last`  in  1  marks the final beat of a packet.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  input beat can be accepted.
- `out_1_data`  out  WIDTH  registered beat for port 1.
- `out_1_last`  out  1  registered last flag for port 1.
- `out_1_valid`  out  1  port 1 register holds a beat.
- `out_1_ready`  in  1  port 1 sink accepts.
- `out_2_data`, `out_2_last`, `out_2_valid`  out, `out_2_ready`  in: same as port 1, for port 2.
- `pkt_cnt_1`  out  16  packets completed on port 1.
- `pkt_cnt_2`  out  16  packets completed on port 2.

## Operation
- FSM states: IDLE, ROUTE_1, ROUTE_2. Reset state is IDLE.
- Target port:
  - In IDLE, the target is `in_sel` (0 selects port 1, 1 selects port 2).
  - In ROUTE_1 the target is port 1; in ROUTE_2 it is port 2. `in_sel` is ignored in both.
- Input acceptance:
  - A beat is accepted when `in_valid && in_ready`.
  - `in_ready` = target register empty OR target `out_x_ready`.
  - The path from `out_x_ready` to `in_ready` is combinational. There is no path from `in_valid` to `in_ready`.
- FSM transitions:
  - IDLE: an accepted beat with `in_last`=0 moves to ROUTE_1 or ROUTE_2 according to `in_sel`. An accepted beat with `in_last`=1 is a single-beat packet, and the FSM stays in IDLE.
  - ROUTE_x: an accepted beat with `in_last`=1 returns to IDLE. Otherwise the FSM holds.
- Output register x, evaluated each cycle:
  - Load if a beat is accepted for x. The register captures data and last, and valid is set to 1.
  - Otherwise, clear valid if `out_x_valid && out_x_ready`.
  - Otherwise, hold.
  - Simultaneous drain and load leaves valid at 1 with the new beat (full throughput).
- Data and last on a port must not change while `out_x_valid`=1 and `out_x_ready`=0.
- The non-target port drains independently, so a stalled port never blocks the other port's drain.
- Packet counters:
  - `pkt_cnt_x` increments when `out_x_valid && out_x_ready && out_x_last`.
  - It wraps from 16'hFFFF to 0 with no saturation.
- A packet never interleaves across ports. Beats on a port appear in input order.

## Timing
- Reset (async assert) clears:
  - All `out_x_valid` and `out_x_last` to 0.
  - `out_x_data` to 0.
  - Counters to 0.
  - FSM to IDLE.
- `in_ready` during reset follows its formula, which gives 1 (both registers empty).
- Reset asserted mid-packet drops the buffered beats and the partial packet with no counter update. The first beat after reset is treated as a packet start.
- Latency: a beat accepted at edge N is visible on `out_x` after edge N (1 cycle).
- Throughput: 1 beat/cycle with the target ready held high.
- Counter update is visible the cycle after the last-beat handshake.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs.
  - Required: all `out_*_valid`=0, counters=0, `in_ready`=1.
  - Deassert, then assert mid-packet: the valid outputs clear immediately, asynchronously, without waiting for an edge.
- **Basic routing:**
  - Send 1-beat packet 16'h00AD with `in_sel`=0: it appears on `out_1` one cycle later, and `pkt_cnt_1`=1.
  - Then send 16'h00AD with `in_sel`=1: it appears on `out_2`, and `pkt_cnt_2`=1.
- **Select lock:** send a 4-beat packet 16'h0001..0004 starting with `in_sel`=1, toggling `in_sel` every beat.
  - Required: all 4 beats on `out_2`, none on `out_1`, and `pkt_cnt_2` increments once.
- **Backpressure:** route to port 1 with `out_1_ready`=0.
  - Required: the first beat is held with stable data, and `in_ready` drops to 0 while the next beat targets port 1.
  - Raise ready: beats drain in order with no loss or duplication.
- **Independence:** hold `out_1_ready`=0 with a beat stuck in port 1, then send a packet with `in_sel`=1 and `out_2_ready`=1.
  - Required: the port 2 packet passes at 1 beat/cycle.
- **Counter wrap:** preload via 65536 single-beat packets to port 1.
  - Required: `pkt_cnt_1` returns to 0, and `pkt_cnt_2` stays 0.

Source files
------------

// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - two-way packet demultiplexer with per-port output registers and packet counters
//
// Steers each input packet (delimited by in_last) to out_1 or out_2. The
// destination is taken from in_sel on the first beat and held until the last
// beat. Each output has a one-entry register that drains independently of the
// other port, so a stalled port never blocks the other one.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_data/in_sel/in_last/in_valid  input beat, destination select, end of packet, beat present
//   in_ready                       input beat can be accepted this cycle
//   out_x_data/out_x_last/out_x_valid  registered beat for port x (x = 1, 2)
//   out_x_ready                    port x sink accepts
//   pkt_cnt_1, pkt_cnt_2           wrapping count of packets completed on each port

module demux2_stream #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_1_data,
    output logic             out_1_last,
    output logic             out_1_valid,
    input  logic             out_1_ready,
    output logic [WIDTH-1:0] out_2_data,
    output logic             out_2_last,
    output logic             out_2_valid,
    input  logic             out_2_ready,
    output logic [15:0]      pkt_cnt_1,
    output logic [15:0]      pkt_cnt_2
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE_1 = 2'd1,
        ROUTE_2 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_1_q, data_1_d, data_2_q, data_2_d;
    logic             last_1_q, last_1_d, last_2_q, last_2_d;
    logic             valid_1_q, valid_1_d, valid_2_q, valid_2_d;
    logic [15:0]      cnt_1_q, cnt_1_d, cnt_2_q, cnt_2_d;

    logic             target_2;
    logic             accept;
    logic             drain_1, drain_2;

    always_comb begin
        // Mid-packet the locked destination wins; in_sel only matters in IDLE.
        target_2 = (state_q == ROUTE_2) || ((state_q == IDLE) && in_sel);

        // Depends only on register state and sink ready, never on in_valid.
        in_ready = target_2 ? (!valid_2_q || out_2_ready)
                            : (!valid_1_q || out_1_ready);
        accept   = in_valid && in_ready;
        drain_1  = valid_1_q && out_1_ready;
        drain_2  = valid_2_q && out_2_ready;

        state_d   = state_q;
        data_1_d  = data_1_q;
        last_1_d  = last_1_q;
        valid_1_d = valid_1_q;
        data_2_d  = data_2_q;
        last_2_d  = last_2_q;
        valid_2_d = valid_2_q;
        cnt_1_d   = cnt_1_q;
        cnt_2_d   = cnt_2_q;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!in_last) begin
                        state_d = in_sel ? ROUTE_2 : ROUTE_1;
                    end
                end
                ROUTE_1, ROUTE_2: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Load takes priority over drain so a simultaneous drain+load keeps
        // valid high with the new beat.
        if (accept && !target_2) begin
            data_1_d  = in_data;
            last_1_d  = in_last;
            valid_1_d = 1'b1;
        end else if (drain_1) begin
            valid_1_d = 1'b0;
        end

        if (accept && target_2) begin
            data_2_d  = in_data;
            last_2_d  = in_last;
            valid_2_d = 1'b1;
        end else if (drain_2) begin
            valid_2_d = 1'b0;
        end

        if (drain_1 && last_1_q) begin
            cnt_1_d = cnt_1_q + 16'd1;
        end
        if (drain_2 && last_2_q) begin
            cnt_2_d = cnt_2_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_1_q  <= '0;
            last_1_q  <= 1'b0;
            valid_1_q <= 1'b0;
            data_2_q  <= '0;
            last_2_q  <= 1'b0;
            valid_2_q <= 1'b0;
            cnt_1_q   <= 16'd0;
            cnt_2_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            data_1_q  <= data_1_d;
            last_1_q  <= last_1_d;
            valid_1_q <= valid_1_d;
            data_2_q  <= data_2_d;
            last_2_q  <= last_2_d;
            valid_2_q <= valid_2_d;
            cnt_1_q   <= cnt_1_d;
            cnt_2_q   <= cnt_2_d;
        end
    end

    assign out_1_data  = data_1_q;
    assign out_1_last  = last_1_q;
    assign out_1_valid = valid_1_q;
    assign out_2_data  = data_2_q;
    assign out_2_last  = last_2_q;
    assign out_2_valid = valid_2_q;
    assign pkt_cnt_1   = cnt_1_q;
    assign pkt_cnt_2   = cnt_2_q;

endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - self-checking bench for demux2_stream

module tb_demux2_stream;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_1_data;
    logic        out_1_last;
    logic        out_1_valid;
    logic        out_1_ready;
    logic [15:0] out_2_data;
    logic        out_2_last;
    logic        out_2_valid;
    logic        out_2_ready;
    logic [15:0] pkt_cnt_1;
    logic [15:0] pkt_cnt_2;

    int n_pass = 0;
    int n_total = 0;

    demux2_stream #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_last     (in_last),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_1_data  (out_1_data),
        .out_1_last  (out_1_last),
        .out_1_valid (out_1_valid),
        .out_1_ready (out_1_ready),
        .out_2_data  (out_2_data),
        .out_2_last  (out_2_last),
        .out_2_valid (out_2_valid),
        .out_2_ready (out_2_ready),
        .pkt_cnt_1   (pkt_cnt_1),
        .pkt_cnt_2   (pkt_cnt_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic l, input logic [15:0] d,
                         input logic r1, input logic r2);
        in_valid    = v;
        in_sel      = s;
        in_last     = l;
        in_data     = d;
        out_1_ready = r1;
        out_2_ready = r2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        @(posedge clk);
        #1;
        drive(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        @(posedge clk);
        #3;
        drive(0, 0, 0, 16'h0, 1, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Vector row: inputs for this cycle and the outputs expected during it.
    typedef struct {
        logic        v, s, l;
        logic [15:0] d;
        logic        r1, r2;
        logic        rdy;
        logic        v1;
        logic [15:0] d1;
        logic        l1;
        logic        v2;
        logic [15:0] d2;
        logic        l2;
        logic [15:0] c1, c2;
    } vec_t;

    function automatic vec_t mk(int v, int s, int l, int d, int r1, int r2, int rdy,
                                int v1, int d1, int l1, int v2, int d2, int l2,
                                int c1, int c2);
        vec_t r;
        r.v = 1'(v);   r.s = 1'(s);   r.l = 1'(l);   r.d = 16'(d);
        r.r1 = 1'(r1); r.r2 = 1'(r2); r.rdy = 1'(rdy);
        r.v1 = 1'(v1); r.d1 = 16'(d1); r.l1 = 1'(l1);
        r.v2 = 1'(v2); r.d2 = 16'(d2); r.l2 = 1'(l2);
        r.c1 = 16'(c1); r.c2 = 16'(c2);
        return r;
    endfunction

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    vec_t tbl[21];

    initial begin
        // Basic routing, select lock, backpressure, independence.
        tbl[0]  = mk(1,0,1,'hAD,1,1, 1, 0,0,0,     0,0,0,     0,0);
        tbl[1]  = mk(1,1,1,'hAD,1,1, 1, 1,'hAD,1,  0,0,0,     0,0);
        tbl[2]  = mk(0,0,0,0,   1,1, 1, 0,0,0,     1,'hAD,1,  1,0);
        tbl[3]  = mk(1,1,0,1,   1,1, 1, 0,0,0,     0,0,0,     1,1);
        tbl[4]  = mk(1,0,0,2,   1,1, 1, 0,0,0,     1,1,0,     1,1);
        tbl[5]  = mk(1,1,0,3,   1,1, 1, 0,0,0,     1,2,0,     1,1);
        tbl[6]  = mk(1,0,1,4,   1,1, 1, 0,0,0,     1,3,0,     1,1);
        tbl[7]  = mk(0,0,0,0,   1,1, 1, 0,0,0,     1,4,1,     1,1);
        tbl[8]  = mk(0,0,0,0,   1,1, 1, 0,0,0,     0,0,0,     1,2);
        tbl[9]  = mk(1,0,0,'h11,0,1, 1, 0,0,0,     0,0,0,     1,2);
        tbl[10] = mk(1,0,0,'h12,0,1, 0, 1,'h11,0,  0,0,0,     1,2);
        tbl[11] = mk(1,0,0,'h12,0,1, 0, 1,'h11,0,  0,0,0,     1,2);
        tbl[12] = mk(1,0,0,'h12,1,1, 1, 1,'h11,0,  0,0,0,     1,2);
        tbl[13] = mk(1,1,1,'h13,1,1, 1, 1,'h12,0,  0,0,0,     1,2);
        tbl[14] = mk(0,0,0,0,   0,1, 0, 1,'h13,1,  0,0,0,     1,2);
        tbl[15] = mk(1,1,0,'h21,0,1, 1, 1,'h13,1,  0,0,0,     1,2);
        tbl[16] = mk(1,0,0,'h22,0,1, 1, 1,'h13,1,  1,'h21,0,  1,2);
        tbl[17] = mk(1,0,1,'h23,0,1, 1, 1,'h13,1,  1,'h22,0,  1,2);
        tbl[18] = mk(0,0,0,0,   0,1, 0, 1,'h13,1,  1,'h23,1,  1,2);
        tbl[19] = mk(0,0,0,0,   1,1, 1, 1,'h13,1,  0,0,0,     1,3);
        tbl[20] = mk(0,0,0,0,   1,1, 1, 0,0,0,     0,0,0,     2,3);

        rst_n = 1'b0;
        drive(0, 0, 0, 16'h0, 1, 1);

        // Reset held with random inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            drive(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            #3;
            chk("rst_v1", 32'(out_1_valid), 0);
            chk("rst_v2", 32'(out_2_valid), 0);
            chk("rst_c1", 32'(pkt_cnt_1), 0);
            chk("rst_c2", 32'(pkt_cnt_2), 0);
            chk("rst_rdy", 32'(in_ready), 1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Mid-packet async reset, then the next beat must start a fresh packet.
        drive(1, 0, 0, 16'h0055, 0, 0);
        @(posedge clk);
        #1;
        chk("mid_v1_loaded", 32'(out_1_valid), 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_v1", 32'(out_1_valid), 0);
        chk("async_v2", 32'(out_2_valid), 0);
        chk("async_rdy", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 1, 1, 16'h0066, 0, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_rst_v2", 32'(out_2_valid), 1);
        chk("post_rst_d2", 32'(out_2_data), 32'h66);
        chk("post_rst_v1", 32'(out_1_valid), 0);
        chk("post_rst_c", 32'({pkt_cnt_1, pkt_cnt_2}), 0);

        // Directed table.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].d, tbl[i].r1, tbl[i].r2);
            #3;
            chk($sformatf("tbl%0d_rdy", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_v1", i), 32'(out_1_valid), 32'(tbl[i].v1));
            chk($sformatf("tbl%0d_v2", i), 32'(out_2_valid), 32'(tbl[i].v2));
            if (tbl[i].v1) begin
                chk($sformatf("tbl%0d_d1", i), 32'(out_1_data), 32'(tbl[i].d1));
                chk($sformatf("tbl%0d_l1", i), 32'(out_1_last), 32'(tbl[i].l1));
            end
            if (tbl[i].v2) begin
                chk($sformatf("tbl%0d_d2", i), 32'(out_2_data), 32'(tbl[i].d2));
                chk($sformatf("tbl%0d_l2", i), 32'(out_2_last), 32'(tbl[i].l2));
            end
            chk($sformatf("tbl%0d_c1", i), 32'(pkt_cnt_1), 32'(tbl[i].c1));
            chk($sformatf("tbl%0d_c2", i), 32'(pkt_cnt_2), 32'(tbl[i].c2));
        end

        // Random traffic against a queue-based reference.
        do_reset();
        begin
            beat_t q1[$];
            beat_t q2[$];
            beat_t b;
            int    c1 = 0;
            int    c2 = 0;
            bit    in_pkt = 0;
            bit    dest2 = 0;
            bit    to2;
            bit    rdy;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(posedge clk);
                #1;
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      16'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
                #3;
                to2 = in_pkt ? dest2 : in_sel;
                rdy = to2 ? (q2.size() == 0 || out_2_ready) : (q1.size() == 0 || out_1_ready);
                chk("rnd_rdy", 32'(in_ready), 32'(rdy));
                chk("rnd_v1", 32'(out_1_valid), 32'(q1.size() != 0));
                chk("rnd_v2", 32'(out_2_valid), 32'(q2.size() != 0));
                if (q1.size() != 0) begin
                    chk("rnd_d1", 32'({out_1_last, out_1_data}), 32'({q1[0].l, q1[0].d}));
                end
                if (q2.size() != 0) begin
                    chk("rnd_d2", 32'({out_2_last, out_2_data}), 32'({q2[0].l, q2[0].d}));
                end
                chk("rnd_c1", 32'(pkt_cnt_1), 32'(c1));
                chk("rnd_c2", 32'(pkt_cnt_2), 32'(c2));
                if (q1.size() != 0 && out_1_ready) begin
                    b = q1.pop_front();
                    if (b.l) c1 = (c1 + 1) % 65536;
                end
                if (q2.size() != 0 && out_2_ready) begin
                    b = q2.pop_front();
                    if (b.l) c2 = (c2 + 1) % 65536;
                end
                if (in_valid && rdy) begin
                    b.d = in_data;
                    b.l = in_last;
                    if (to2) q2.push_back(b);
                    else     q1.push_back(b);
                    if (in_last) begin
                        in_pkt = 0;
                    end else begin
                        if (!in_pkt) dest2 = in_sel;
                        in_pkt = 1;
                    end
                end
            end
        end

        // Counter wrap: 65536 single-beat packets to port 1.
        do_reset();
        @(posedge clk);
        #1;
        drive(1, 0, 1, 16'h00AA, 1, 1);
        repeat (65536) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("wrap_c1_ffff", 32'(pkt_cnt_1), 32'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_c1_zero", 32'(pkt_cnt_1), 0);
        chk("wrap_c2_zero", 32'(pkt_cnt_2), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
